cnn_layer_sequencer: RTL and testbench

//  Parametrised network-level controller for the CNN accelerator. Walks a layer descriptor list in memory via a
//  DMA req/ack handshake and issues one conv/pool job per layer to the compute engines over a valid/ready handshake.

---
 rtl/cnn_layer_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// Network-level CNN layer sequencer: reads a layer descriptor list over a DMA req/ack port and
// issues one conv/pool job per layer, tracking feature-map geometry and ping-pong buffer bases.
module cnn_layer_sequencer #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int MAX_LAYERS    = 16,
    parameter int INIT_IMG_SIZE = 32,
    parameter int INIT_CH       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] desc_base,
    input  logic [ADDR_W-1:0] buf_a_base,
    input  logic [ADDR_W-1:0] buf_b_base,
    output logic              dma_req,
    output logic [ADDR_W-1:0] dma_addr,
    output logic [1:0]        dma_len,
    input  logic              dma_ack,
    input  logic [DATA_W-1:0] dma_d0,
    input  logic [DATA_W-1:0] dma_d1,
    input  logic [DATA_W-1:0] dma_d2,
    output logic              job_valid,
    input  logic              job_ready,
    output logic              job_type,
    output logic [ADDR_W-1:0] job_in_addr,
    output logic [ADDR_W-1:0] job_out_addr,
    output logic [ADDR_W-1:0] job_wt_addr,
    output logic [DATA_W-1:0] job_img_size,
    output logic [DATA_W-1:0] job_in_ch,
    output logic [DATA_W-1:0] job_k,
    output logic [DATA_W-1:0] job_nf,
    input  logic              job_done,
    output logic              busy,
    output logic [DATA_W-1:0] layer_idx,
    output logic              done,
    output logic              error,
    output logic [2:0]        err_code,
    output logic [DATA_W-1:0] out_size,
    output logic [DATA_W-1:0] out_ch,
    output logic [3:0]        stateDbg
);

    typedef enum logic [3:0] {
        IDLE, FCNT, CHECKN, FHDR, VALID, ISSUE, RUN, NEXT, DONE, ERR
    } state_t;

    state_t state, nextState;

    logic [ADDR_W-1:0] descBaseR, ptr, bufIn, bufOut;
    logic [DATA_W-1:0] nLayers, hdrType, hdrK, hdrF, curSize, curCh;
    logic [2:0]        vErr;
    logic              isConv;
    logic [ADDR_W-1:0] fA, kA, fkk;

    assign stateDbg = state;
    assign isConv   = (hdrType == DATA_W'(1));
    assign fA       = ADDR_W'(hdrF);
    assign kA       = ADDR_W'(hdrK);
    assign fkk      = fA * kA * kA;

    // Descriptor checks, first failing rule wins.
    always_comb begin
        vErr = 3'd0;
        if (hdrType > DATA_W'(1)) begin
            vErr = 3'd2;
        end else if (isConv) begin
            if (hdrK == '0 || !hdrK[0] || hdrK > curSize) vErr = 3'd3;
            else if (hdrF == '0)                           vErr = 3'd4;
        end else if (curSize < DATA_W'(2)) begin
            vErr = 3'd5;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Handshakes: dma_req holds with addr/len stable until a cycle with dma_ack=1, which
    // completes the read; job_valid holds with all job fields stable until a cycle with
    // job_ready=1, which transfers the job. Neither request is withdrawn except by reset/abort.
    always_comb begin
        nextState = state;
        dma_req   = 1'b0;
        dma_addr  = '0;
        dma_len   = 2'd0;
        job_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) nextState = FCNT;
            end
            FCNT: begin
                dma_req  = 1'b1;
                dma_addr = descBaseR;
                dma_len  = 2'd1;
                if (dma_ack) nextState = CHECKN;
            end
            CHECKN: begin
                if (nLayers == '0)                        nextState = DONE;
                else if (nLayers > DATA_W'(MAX_LAYERS))   nextState = ERR;
                else                                      nextState = FHDR;
            end
            FHDR: begin
                dma_req  = 1'b1;
                dma_addr = ptr;
                dma_len  = 2'd3;
                if (dma_ack) nextState = VALID;
            end
            VALID:   nextState = (vErr != 3'd0) ? ERR : ISSUE;
            ISSUE: begin
                job_valid = 1'b1;
                if (job_ready) nextState = RUN;
            end
            RUN:     if (job_done) nextState = NEXT;
            NEXT:    nextState = (layer_idx == nLayers) ? DONE : FHDR;
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) nextState = FCNT;
            end
            ERR: begin
                busy  = 1'b0;
                error = 1'b1;
                if (start) nextState = FCNT;
            end
            default: nextState = IDLE;
        endcase
        if (abort) nextState = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            descBaseR    <= '0;
            ptr          <= '0;
            bufIn        <= '0;
            bufOut       <= '0;
            nLayers      <= '0;
            hdrType      <= '0;
            hdrK         <= '0;
            hdrF         <= '0;
            curSize      <= DATA_W'(INIT_IMG_SIZE);
            curCh        <= DATA_W'(INIT_CH);
            layer_idx    <= '0;
            err_code     <= 3'd0;
            out_size     <= '0;
            out_ch       <= '0;
            job_type     <= 1'b0;
            job_in_addr  <= '0;
            job_out_addr <= '0;
            job_wt_addr  <= '0;
            job_img_size <= '0;
            job_in_ch    <= '0;
            job_k        <= '0;
            job_nf       <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        descBaseR <= desc_base;
                        bufIn     <= buf_a_base;
                        bufOut    <= buf_b_base;
                        curSize   <= DATA_W'(INIT_IMG_SIZE);
                        curCh     <= DATA_W'(INIT_CH);
                        layer_idx <= '0;
                        err_code  <= 3'd0;
                    end
                end
                FCNT: begin
                    if (dma_ack) begin
                        nLayers <= dma_d0;
                        ptr     <= descBaseR + ADDR_W'(1);
                    end
                end
                CHECKN: begin
                    if (nLayers != '0 && nLayers > DATA_W'(MAX_LAYERS)) err_code <= 3'd1;
                end
                FHDR: begin
                    if (dma_ack) begin
                        hdrType <= dma_d0;
                        hdrK    <= dma_d1;
                        hdrF    <= dma_d2;
                    end
                end
                VALID: begin
                    if (vErr != 3'd0) begin
                        err_code <= vErr;
                    end else begin
                        job_type     <= isConv;
                        job_in_addr  <= bufIn;
                        job_out_addr <= bufOut;
                        job_wt_addr  <= isConv ? ptr + ADDR_W'(3) : '0;
                        job_img_size <= curSize;
                        job_in_ch    <= curCh;
                        job_k        <= isConv ? hdrK : DATA_W'(2);
                        job_nf       <= isConv ? hdrF : curCh;
                    end
                end
                RUN: begin
                    // Geometry advances only once the engine reports the layer finished.
                    if (job_done) begin
                        if (isConv) begin
                            curSize <= curSize - (hdrK >> 1) - (hdrK >> 1);
                            curCh   <= hdrF;
                            ptr     <= ptr + ADDR_W'(3) + fkk;
                        end else begin
                            curSize <= curSize >> 1;
                            ptr     <= ptr + ADDR_W'(1);
                        end
                        bufIn     <= bufOut;
                        bufOut    <= bufIn;
                        layer_idx <= layer_idx + DATA_W'(1);
                    end
                end
                default: ;
            endcase
            if (nextState == DONE && state != DONE) begin
                out_size <= curSize;
                out_ch   <= curCh;
            end
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer: memory-backed DMA responder, handshaking engine
// model, and scoreboard queues for expected DMA reads and issued jobs.
module tb_cnn_layer_sequencer;

    localparam int AW  = 20;
    localparam int DW  = 16;
    localparam int JW  = 1 + 3 * AW + 4 * DW;
    localparam int DMW = AW + 2;
    localparam logic [AW-1:0] BUF_A = 20'h10000;
    localparam logic [AW-1:0] BUF_B = 20'h20000;

    logic          clk, reset, start, abort;
    logic [AW-1:0] desc_base, buf_a_base, buf_b_base;
    logic          dma_req, dma_ack;
    logic [AW-1:0] dma_addr;
    logic [1:0]    dma_len;
    logic [DW-1:0] dma_d0, dma_d1, dma_d2;
    logic          job_valid, job_ready, job_type, job_done;
    logic [AW-1:0] job_in_addr, job_out_addr, job_wt_addr;
    logic [DW-1:0] job_img_size, job_in_ch, job_k, job_nf;
    logic          busy, done, error;
    logic [DW-1:0] layer_idx, out_size, out_ch;
    logic [2:0]    err_code;
    logic [3:0]    stateDbg;

    logic [DW-1:0]  mem [0:4095];
    logic [JW-1:0]  exp_q[$];
    logic [DMW-1:0] dma_q[$];
    int nChecks = 0;
    int nFails = 0;
    int dmaBudget = 1000000;
    int readyHold = 0;
    int doneDelay = 2;
    int jobsSeen = 0;

    cnn_layer_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .desc_base(desc_base), .buf_a_base(buf_a_base), .buf_b_base(buf_b_base),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_len(dma_len), .dma_ack(dma_ack),
        .dma_d0(dma_d0), .dma_d1(dma_d1), .dma_d2(dma_d2),
        .job_valid(job_valid), .job_ready(job_ready), .job_type(job_type),
        .job_in_addr(job_in_addr), .job_out_addr(job_out_addr), .job_wt_addr(job_wt_addr),
        .job_img_size(job_img_size), .job_in_ch(job_in_ch), .job_k(job_k), .job_nf(job_nf),
        .job_done(job_done), .busy(busy), .layer_idx(layer_idx), .done(done), .error(error),
        .err_code(err_code), .out_size(out_size), .out_ch(out_ch), .stateDbg(stateDbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [JW-1:0] packJob(input logic t, input logic [AW-1:0] ia,
        input logic [AW-1:0] oa, input logic [AW-1:0] wa, input logic [DW-1:0] sz,
        input logic [DW-1:0] ch, input logic [DW-1:0] k, input logic [DW-1:0] nf);
        return {t, ia, oa, wa, sz, ch, k, nf};
    endfunction

    function automatic logic [JW-1:0] dutJob();
        return packJob(job_type, job_in_addr, job_out_addr, job_wt_addr,
                       job_img_size, job_in_ch, job_k, job_nf);
    endfunction

    // DMA responder: checks each request against dma_q, answers from mem one cycle later
    initial begin
        logic [11:0]    ix;
        logic [DMW-1:0] expDma;
        dma_ack = 1'b0;
        dma_d0 = '0; dma_d1 = '0; dma_d2 = '0;
        forever begin
            @(negedge clk);
            if (dma_req && !reset && !abort && dmaBudget > 0) begin
                dmaBudget--;
                nChecks++;
                if (dma_q.size() == 0) begin
                    nFails++;
                    $display("FAIL dma_unexpected: got addr=%h len=%0d, expected no request", dma_addr, dma_len);
                end else begin
                    expDma = dma_q.pop_front();
                    if ({dma_addr, dma_len} !== expDma)
                        begin nFails++; $display("FAIL dma_request: got addr=%h len=%0d, expected addr=%h len=%0d",
                                  dma_addr, dma_len, expDma[DMW-1:2], expDma[1:0]); end
                end
                ix = dma_addr[11:0];
                dma_d0 = mem[ix];
                dma_d1 = mem[ix + 12'd1];
                dma_d2 = mem[ix + 12'd2];
                dma_ack = 1'b1;
                @(negedge clk);
                dma_ack = 1'b0;
            end
        end
    end

    // Engine model: optional ready hold with stability checks, scoreboard compare on accept
    initial begin
        logic [JW-1:0] snap, expJob;
        logic dropped;
        job_ready = 1'b0;
        job_done = 1'b0;
        forever begin
            @(negedge clk);
            if (job_valid && !reset && !abort) begin
                snap = dutJob();
                for (int i = 0; i < readyHold; i++) begin
                    @(negedge clk);
                    nChecks++;
                    if (job_valid !== 1'b1 || dutJob() !== snap)
                        begin nFails++; $display("FAIL job_stable: got valid=%b fields=%h, expected valid=1 fields=%h",
                                  job_valid, dutJob(), snap); end
                end
                job_ready = 1'b1;
                jobsSeen++;
                nChecks++;
                if (exp_q.size() == 0) begin
                    nFails++;
                    $display("FAIL job_unexpected: got job %h, expected no job", dutJob());
                end else begin
                    expJob = exp_q.pop_front();
                    if (dutJob() !== expJob)
                        begin nFails++; $display("FAIL job_fields: got %h, expected %h", dutJob(), expJob); end
                end
                @(negedge clk);
                job_ready = 1'b0;
                nChecks++;
                if (job_valid !== 1'b0)
                    begin nFails++; $display("FAIL job_valid_drop: got %b, expected 0", job_valid); end
                dropped = 1'b0;
                for (int i = 0; i < doneDelay; i++) begin
                    @(negedge clk);
                    if (reset || abort) dropped = 1'b1;
                end
                if (!dropped) begin
                    job_done = 1'b1;
                    @(negedge clk);
                    job_done = 1'b0;
                end
            end
        end
    end

    // Driver tasks
    task automatic startRun(input logic [AW-1:0] base, input logic [AW-1:0] a, input logic [AW-1:0] b);
        @(negedge clk);
        desc_base = base; buf_a_base = a; buf_b_base = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitEnd(output int cycles);
        cycles = 0;
        while (!(done || error) && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic setHdr(input int a, input int t, input int k, input int f);
        mem[a] = DW'(t); mem[a + 1] = DW'(k); mem[a + 2] = DW'(f);
    endtask

    // Two-layer network: conv K=3 F=4 then pool; L1 header lands at 0x128
    task automatic setupNet1();
        mem[12'h100] = 16'd2;
        setHdr(12'h101, 1, 3, 4);
        setHdr(12'h128, 0, 0, 0);
        dma_q.push_back({20'h00100, 2'd1});
        dma_q.push_back({20'h00101, 2'd3});
        dma_q.push_back({20'h00128, 2'd3});
        exp_q.push_back(packJob(1'b1, BUF_A, BUF_B, 20'h00104, 16'd32, 16'd1, 16'd3, 16'd4));
        exp_q.push_back(packJob(1'b0, BUF_B, BUF_A, 20'h00000, 16'd30, 16'd4, 16'd2, 16'd4));
    endtask

    // Model of a random valid network; fills mem and the scoreboard queues
    task automatic buildNet(input int base, input int n, input logic [AW-1:0] a, input logic [AW-1:0] b,
                            output logic [DW-1:0] fSize, output logic [DW-1:0] fCh);
        int sz, ch, p, k, f;
        logic [AW-1:0] ia, oa, t;
        sz = 32; ch = 1; p = base + 1; ia = a; oa = b;
        mem[base] = DW'(n);
        dma_q.push_back({AW'(base), 2'd1});
        for (int l = 0; l < n; l++) begin
            dma_q.push_back({AW'(p), 2'd3});
            if (sz >= 2 && $urandom_range(0, 1) == 0) begin
                setHdr(p, 0, $urandom_range(0, 9), $urandom_range(0, 9));
                exp_q.push_back(packJob(1'b0, ia, oa, '0, DW'(sz), DW'(ch), 16'd2, DW'(ch)));
                sz = sz / 2;
                p = p + 1;
            end else begin
                k = 2 * $urandom_range(0, 2) + 1;
                while (k > sz) k = k - 2;
                f = $urandom_range(1, 8);
                setHdr(p, 1, k, f);
                exp_q.push_back(packJob(1'b1, ia, oa, AW'(p + 3), DW'(sz), DW'(ch), DW'(k), DW'(f)));
                sz = sz - (k - 1);
                ch = f;
                p = p + 3 + f * k * k;
            end
            t = ia; ia = oa; oa = t;
        end
        fSize = DW'(sz);
        fCh = DW'(ch);
    endtask

    // Scenarios
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        nChecks++;
        if ({dma_req, job_valid, busy, done, error} !== 5'b0)
            begin nFails++; $display("FAIL reset_flags: got %b, expected 00000", {dma_req, job_valid, busy, done, error}); end
        nChecks++;
        if ({err_code, layer_idx, out_size, out_ch} !== '0)
            begin nFails++; $display("FAIL reset_status: got code=%0d idx=%0d size=%0d ch=%0d, expected all 0",
                      err_code, layer_idx, out_size, out_ch); end
        nChecks++;
        if (dutJob() !== '0 || dma_addr !== '0 || dma_len !== 2'd0)
            begin nFails++; $display("FAIL reset_fields: got job=%h addr=%h len=%0d, expected 0", dutJob(), dma_addr, dma_len); end
    endtask

    task automatic test_basic();
        int cyc, jobs0;
        setupNet1();
        jobs0 = jobsSeen;
        startRun(20'h00100, BUF_A, BUF_B);
        nChecks++;
        if ({dma_req, dma_addr, dma_len} !== {1'b1, 20'h00100, 2'd1})
            begin nFails++; $display("FAIL start_latency: got req=%b addr=%h len=%0d, expected req=1 addr=00100 len=1",
                      dma_req, dma_addr, dma_len); end
        waitEnd(cyc);
        nChecks++;
        if ({done, error, busy} !== 3'b100 || out_size !== 16'd15 || out_ch !== 16'd4 || layer_idx !== 16'd2)
            begin nFails++; $display("FAIL basic_result: got done=%b err=%b busy=%b size=%0d ch=%0d idx=%0d, expected 1 0 0 15 4 2",
                      done, error, busy, out_size, out_ch, layer_idx); end
        nChecks++;
        if (jobsSeen - jobs0 !== 2 || exp_q.size() !== 0 || dma_q.size() !== 0)
            begin nFails++; $display("FAIL basic_queues: got jobs=%0d exp_left=%0d dma_left=%0d, expected 2 0 0",
                      jobsSeen - jobs0, exp_q.size(), dma_q.size()); end
    endtask

    task automatic test_zero_layers();
        int cyc, jobs0;
        mem[12'h200] = 16'd0;
        dma_q.push_back({20'h00200, 2'd1});
        jobs0 = jobsSeen;
        startRun(20'h00200, BUF_A, BUF_B);
        waitEnd(cyc);
        nChecks++;
        if (cyc > 2 || done !== 1'b1)
            begin nFails++; $display("FAIL zero_latency: got done=%b after %0d cycles, expected done=1 within 2", done, cyc); end
        nChecks++;
        if (out_size !== 16'd32 || out_ch !== 16'd1 || jobsSeen !== jobs0)
            begin nFails++; $display("FAIL zero_result: got size=%0d ch=%0d jobs=%0d, expected 32 1 0",
                      out_size, out_ch, jobsSeen - jobs0); end
    endtask

    task automatic test_desc_errors();
        int tT[5] = '{3, 1, 1, 1, 1};
        int kT[5] = '{3, 4, 0, 33, 3};
        int fT[5] = '{4, 2, 2, 1, 0};
        int cT[5] = '{2, 3, 3, 3, 4};
        int cyc, jobs0;
        for (int i = 0; i < 5; i++) begin
            mem[12'h300] = 16'd1;
            setHdr(12'h301, tT[i], kT[i], fT[i]);
            dma_q.push_back({20'h00300, 2'd1});
            dma_q.push_back({20'h00301, 2'd3});
            jobs0 = jobsSeen;
            startRun(20'h00300, BUF_A, BUF_B);
            nChecks++;
            if (error !== 1'b0 || err_code !== 3'd0)
                begin nFails++; $display("FAIL start_clears[%0d]: got error=%b code=%0d, expected 0 0", i, error, err_code); end
            waitEnd(cyc);
            nChecks++;
            if ({done, error} !== 2'b01 || err_code !== 3'(cT[i]) || jobsSeen !== jobs0)
                begin nFails++; $display("FAIL desc_err[%0d]: got done=%b error=%b code=%0d jobs=%0d, expected 0 1 %0d 0",
                          i, done, error, err_code, jobsSeen - jobs0, cT[i]); end
        end
        // conv K=31 shrinks 32 -> 2, pool -> 1, second pool underflows
        mem[12'h300] = 16'd3;
        setHdr(12'h301, 1, 31, 1);
        setHdr(12'h6C5, 0, 0, 0);
        setHdr(12'h6C6, 0, 0, 0);
        dma_q.push_back({20'h00300, 2'd1});
        dma_q.push_back({20'h00301, 2'd3});
        dma_q.push_back({20'h006C5, 2'd3});
        dma_q.push_back({20'h006C6, 2'd3});
        exp_q.push_back(packJob(1'b1, BUF_A, BUF_B, 20'h00304, 16'd32, 16'd1, 16'd31, 16'd1));
        exp_q.push_back(packJob(1'b0, BUF_B, BUF_A, 20'h00000, 16'd2, 16'd1, 16'd2, 16'd1));
        startRun(20'h00300, BUF_A, BUF_B);
        waitEnd(cyc);
        nChecks++;
        if (error !== 1'b1 || err_code !== 3'd5 || layer_idx !== 16'd2 || exp_q.size() !== 0 || dma_q.size() !== 0)
            begin nFails++; $display("FAIL size_underflow: got error=%b code=%0d idx=%0d exp_left=%0d dma_left=%0d, expected 1 5 2 0 0",
                      error, err_code, layer_idx, exp_q.size(), dma_q.size()); end
    endtask

    task automatic test_ready_hold();
        int cyc;
        readyHold = 5;
        setupNet1();
        startRun(20'h00100, BUF_A, BUF_B);
        waitEnd(cyc);
        readyHold = 0;
        nChecks++;
        if (done !== 1'b1 || out_size !== 16'd15 || out_ch !== 16'd4 || exp_q.size() !== 0)
            begin nFails++; $display("FAIL hold_result: got done=%b size=%0d ch=%0d exp_left=%0d, expected 1 15 4 0",
                      done, out_size, out_ch, exp_q.size()); end
    endtask

    task automatic test_reset_in_run();
        int cyc, jobs0;
        doneDelay = 10;
        setupNet1();
        jobs0 = jobsSeen;
        startRun(20'h00100, BUF_A, BUF_B);
        cyc = 0;
        while (jobsSeen == jobs0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        nChecks++;
        if (cyc >= 100 || busy !== 1'b1 || job_valid !== 1'b0)
            begin nFails++; $display("FAIL reach_run: got cycles=%0d busy=%b valid=%b, expected <100 1 0", cyc, busy, job_valid); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        nChecks++;
        if ({dma_req, job_valid, busy, done, error, err_code} !== '0 || layer_idx !== '0 || dutJob() !== '0)
            begin nFails++; $display("FAIL reset_in_run: got flags=%b code=%0d idx=%0d job=%h, expected all 0",
                      {dma_req, job_valid, busy, done, error}, err_code, layer_idx, dutJob()); end
        nChecks++;
        if (exp_q.size() !== 1 || dma_q.size() !== 1)
            begin nFails++; $display("FAIL reset_pending: got exp_left=%0d dma_left=%0d, expected 1 1", exp_q.size(), dma_q.size()); end
        exp_q.delete();
        dma_q.delete();
        doneDelay = 2;
        setupNet1();
        startRun(20'h00100, BUF_A, BUF_B);
        waitEnd(cyc);
        nChecks++;
        if (done !== 1'b1 || out_size !== 16'd15 || out_ch !== 16'd4 || exp_q.size() !== 0 || dma_q.size() !== 0)
            begin nFails++; $display("FAIL rerun_result: got done=%b size=%0d ch=%0d exp_left=%0d dma_left=%0d, expected 1 15 4 0 0",
                      done, out_size, out_ch, exp_q.size(), dma_q.size()); end
    endtask

    task automatic test_count_and_abort();
        int cyc;
        mem[12'h500] = 16'd17;
        dma_q.push_back({20'h00500, 2'd1});
        startRun(20'h00500, BUF_A, BUF_B);
        waitEnd(cyc);
        nChecks++;
        if (error !== 1'b1 || err_code !== 3'd1 || dma_q.size() !== 0)
            begin nFails++; $display("FAIL count_max: got error=%b code=%0d dma_left=%0d, expected 1 1 0", error, err_code, dma_q.size()); end
        mem[12'h510] = 16'd2;
        dma_q.push_back({20'h00510, 2'd1});
        dmaBudget = 1;
        startRun(20'h00510, BUF_A, BUF_B);
        cyc = 0;
        while (!(dma_req && dma_len == 2'd3) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        nChecks++;
        if (cyc >= 50 || dma_addr !== 20'h00511)
            begin nFails++; $display("FAIL reach_fhdr: got cycles=%0d addr=%h, expected <50 00511", cyc, dma_addr); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        dmaBudget = 1000000;
        nChecks++;
        if ({dma_req, busy, done, error} !== 4'b0 || err_code !== 3'd0)
            begin nFails++; $display("FAIL abort_fhdr: got req=%b busy=%b done=%b err=%b code=%0d, expected all 0",
                      dma_req, busy, done, error, err_code); end
        @(negedge clk);
        desc_base = 20'h00510;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        nChecks++;
        if (dma_req !== 1'b0 || busy !== 1'b0)
            begin nFails++; $display("FAIL abort_wins: got req=%b busy=%b, expected 0 0", dma_req, busy); end
    endtask

    task automatic test_back_to_back();
        int bases[2] = '{12'h800, 12'hC00};
        int n, cyc;
        logic [AW-1:0] a, b;
        logic [DW-1:0] fSize, fCh;
        for (int r = 0; r < 2; r++) begin
            n = $urandom_range(1, 4);
            a = AW'($urandom_range(0, 20'hFFFFF));
            b = AW'($urandom_range(0, 20'hFFFFF));
            buildNet(bases[r], n, a, b, fSize, fCh);
            startRun(AW'(bases[r]), a, b);
            waitEnd(cyc);
            nChecks++;
            if (done !== 1'b1 || out_size !== fSize || out_ch !== fCh || layer_idx !== DW'(n))
                begin nFails++; $display("FAIL b2b_result[%0d]: got done=%b size=%0d ch=%0d idx=%0d, expected 1 %0d %0d %0d",
                          r, done, out_size, out_ch, layer_idx, fSize, fCh, n); end
            nChecks++;
            if (exp_q.size() !== 0 || dma_q.size() !== 0)
                begin nFails++; $display("FAIL b2b_queues[%0d]: got exp_left=%0d dma_left=%0d, expected 0 0",
                          r, exp_q.size(), dma_q.size()); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        desc_base = '0; buf_a_base = '0; buf_b_base = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_zero_layers();
        test_desc_errors();
        test_ready_hold();
        test_reset_in_run();
        test_count_and_abort();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
